qdr_port_arbiter: RTL

//  Shares one QDR2PController user port among NPORTS requesters. Read and write channels are arbitrated

---
 rtl/qdr_arb_pkg.sv | 32 +++
 rtl/qdr_tag_fifo.sv | 55 +++++
 rtl/qdr_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/qdr_arb_pkg.sv
// Shared types and the rotating priority encoder used by both arbitration channels.
package qdr_arb_pkg;

  localparam int unsigned NPORTS_MAX    = 8;
  localparam int unsigned PORT_IDX_BITS = $clog2(NPORTS_MAX);

  typedef logic [PORT_IDX_BITS-1:0] port_idx_t;

  typedef struct packed {
    logic      found;
    port_idx_t idx;
  } rr_pick_t;

  // Mask off requesters below start, take the lowest survivor; if none survive, wrap to the
  // lowest requester overall. Unused upper bits of req must be zero.
  function automatic rr_pick_t rr_pick(input logic [NPORTS_MAX-1:0] req, input port_idx_t start);
    logic [NPORTS_MAX-1:0] mask;
    logic [NPORTS_MAX-1:0] cand;
    rr_pick_t              pick;
    mask = {NPORTS_MAX{1'b1}} << start;
    cand = ((req & mask) != '0) ? (req & mask) : req;
    pick = '0;
    for (int i = NPORTS_MAX - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick.found = 1'b1;
        pick.idx   = port_idx_t'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/qdr_tag_fifo.sv
// Synchronous FIFO of requester indices; one entry per read burst in flight.
module qdr_tag_fifo
  import qdr_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  port_idx_t push_tag,
  input  logic      pop,
  output port_idx_t pop_tag,
  output logic      empty,
  output logic      full
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  port_idx_t           mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                do_push, do_pop;

  // Pop frees a slot before push claims one, so push-at-full is fine when paired with a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_tag;
  end

  assign pop_tag = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_BITS + 1)'(DEPTH));

endmodule

// File: rtl/qdr_port_arbiter.sv
// Round-robin sharing of one QDR-II+ controller user port between NPORTS requesters.
// Reads and writes arbitrate independently; read completions are routed back by a tag FIFO.
module qdr_port_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int unsigned NPORTS          = 4,
  parameter int unsigned ADDR_BITS       = 18,
  parameter int unsigned DATA_BITS       = 144,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ram_ready,
  input  logic [NPORTS-1:0]           rd_req,
  input  logic [NPORTS*ADDR_BITS-1:0] rd_addr,
  output logic [NPORTS-1:0]           rd_ack,
  output logic [NPORTS-1:0]           rd_valid,
  output logic [DATA_BITS-1:0]        rd_data,
  input  logic [NPORTS-1:0]           wr_req,
  input  logic [NPORTS*ADDR_BITS-1:0] wr_addr,
  input  logic [NPORTS*DATA_BITS-1:0] wr_data,
  output logic [NPORTS-1:0]           wr_ack,
  output logic                        ram_rd_en,
  output logic [ADDR_BITS-1:0]        ram_rd_addr,
  input  logic                        ram_rd_valid,
  input  logic [DATA_BITS-1:0]        ram_rd_data,
  output logic                        ram_wr_en,
  output logic [ADDR_BITS-1:0]        ram_wr_addr,
  output logic [DATA_BITS-1:0]        ram_wr_data,
  output logic                        rd_orphan
);

  // The start registers hold where the next search begins (last grant + 1), so a reset value
  // of port 0 gives port 0 first priority.
  port_idx_t              rd_start_q, wr_start_q;
  rr_pick_t               rd_pick, wr_pick;
  logic [ADDR_BITS-1:0]   rd_sel_addr, wr_sel_addr;
  logic [DATA_BITS-1:0]   wr_sel_data;
  logic                   rd_grant, wr_grant, hazard;
  logic                   fifo_empty, fifo_full;
  port_idx_t              ret_tag;
  logic                   ret_ok;
  logic [NPORTS-1:0]      ret_onehot;

  function automatic port_idx_t next_start(input port_idx_t idx);
    return (idx == port_idx_t'(NPORTS - 1)) ? '0 : idx + port_idx_t'(1);
  endfunction

  // Pick a candidate per channel and mux out its address/data.
  always_comb begin
    rd_pick     = rr_pick(NPORTS_MAX'(rd_req), rd_start_q);
    wr_pick     = rr_pick(NPORTS_MAX'(wr_req), wr_start_q);
    rd_sel_addr = '0;
    wr_sel_addr = '0;
    wr_sel_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rd_pick.idx == port_idx_t'(i)) rd_sel_addr = rd_addr[i*ADDR_BITS +: ADDR_BITS];
      if (wr_pick.idx == port_idx_t'(i)) begin
        wr_sel_addr = wr_addr[i*ADDR_BITS +: ADDR_BITS];
        wr_sel_data = wr_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Gating and grants. Tag FIFO occupancy is the outstanding-read count, so full closes the
  // read gate. A read colliding with this cycle's write address waits so it sees the new data.
  always_comb begin
    wr_grant = ram_ready && wr_pick.found;
    hazard   = wr_grant && rd_pick.found && (rd_sel_addr == wr_sel_addr);
    rd_grant = ram_ready && rd_pick.found && !fifo_full && !hazard;
    rd_ack   = '0;
    wr_ack   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      rd_ack[i] = rd_grant && (rd_pick.idx == port_idx_t'(i));
      wr_ack[i] = wr_grant && (wr_pick.idx == port_idx_t'(i));
    end
  end

  // Completion routing: only completions with a queued tag are forwarded.
  always_comb begin
    ret_ok     = ram_rd_valid && !fifo_empty;
    ret_onehot = '0;
    for (int i = 0; i < NPORTS; i++) begin
      ret_onehot[i] = ret_ok && (ret_tag == port_idx_t'(i));
    end
  end

  qdr_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_grant),
    .push_tag (rd_pick.idx),
    .pop      (ram_rd_valid),
    .pop_tag  (ret_tag),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Round-robin pointers advance only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_start_q <= '0;
      wr_start_q <= '0;
    end else begin
      if (rd_grant) rd_start_q <= next_start(rd_pick.idx);
      if (wr_grant) wr_start_q <= next_start(wr_pick.idx);
    end
  end

  // Registered issue to the controller; enables are single-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_rd_en <= rd_grant;
      ram_wr_en <= wr_grant;
      if (rd_grant) ram_rd_addr <= rd_sel_addr;
      if (wr_grant) begin
        ram_wr_addr <= wr_sel_addr;
        ram_wr_data <= wr_sel_data;
      end
    end
  end

  // Registered return path and sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= '0;
      rd_data   <= '0;
      rd_orphan <= 1'b0;
    end else begin
      rd_valid <= ret_onehot;
      if (ret_ok) rd_data <= ram_rd_data;
      if (ram_rd_valid && fifo_empty) rd_orphan <= 1'b1;
    end
  end

endmodule
